sd_cmd_sequencer: RTL and testbench

SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

---
 rtl/sd_pkg.sv | 39 +++
 rtl/sd_crc7.sv | 19 +
 rtl/sd_cmd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI command sequencer.
// Holds the state enum, command indices, R1 bits and the fixed CRC table.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SEND,
    POLL,
    EXTRA,
    POST,
    FIN
  } state_t;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD24  = 6'd24;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD55  = 6'd55;

  localparam int R1_IDLE        = 0;
  localparam int R1_ILLEGAL_CMD = 2;

  localparam logic [7:0] BYTE_FF = 8'hFF;

  // Only CMD0 and CMD8 need a valid CRC in SPI mode; the
  // trailing end bit is already folded into these bytes.
  function automatic logic [7:0] crc_fixed(
    input logic [5:0] idx
  );
    logic [7:0] b;
    b = 8'h01;
    if (idx == CMD0) b = 8'h95;
    if (idx == CMD8) b = 8'h87;
    return b;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7+x^3+1, init 0) over a 40-bit command head.
// Ports: data[39:0] command bits MSB first, crc[6:0] result.
module sd_crc7 (
  input  logic [39:0] data,
  output logic [6:0]  crc
);

  logic fb;

  always_comb begin
    crc = '0;
    fb  = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD SPI command sequencer: frames a command, polls for R1, reads
// optional trailing bytes, then releases cs. Drives a byte engine via
// txrx_execute/txrx_out_byte and consumes txrx_in_byte on
// txrx_finished. Status: busy, done, timeout, r1, resp_data, cs.
// Define SD_CMD_CRC7_EN to compute CRC7; otherwise a fixed table.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int POLL_MAX    = 8,
  parameter int EXTRA_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_long,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  r1,
  output logic [31:0] resp_data,
  output logic        cs,
  output logic        txrx_execute,
  output logic [7:0]  txrx_out_byte,
  input  logic [7:0]  txrx_in_byte,
  input  logic        txrx_finished,
  input  logic        txrx_busy
);

  localparam int MAX_PE =
    (POLL_MAX > EXTRA_BYTES) ? POLL_MAX : EXTRA_BYTES;
  localparam int MAXN = (MAX_PE > 6) ? MAX_PE : 6;
  localparam int CW   = $clog2(MAXN + 1);

  localparam logic [CW-1:0] SEND_LAST  = CW'(5);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_MAX - 1);
  localparam logic [CW-1:0] EXTRA_LAST = CW'(EXTRA_BYTES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [47:0]   frame;
  logic          long_q;
  logic          pend;
  logic [39:0]   head;
  logic [7:0]    crc_byte;
  logic [7:0]    next_byte;
  logic          byte_done;
  logic          in_xfer;

  assign head = {2'b01, cmd_index, cmd_arg};

`ifdef SD_CMD_CRC7_EN
  logic [6:0] crc7;

  sd_crc7 u_crc7 (
    .data (head),
    .crc  (crc7)
  );

  assign crc_byte = {crc7, 1'b1};
`else
  assign crc_byte = crc_fixed(cmd_index);
`endif

  // A finish only counts for a transfer we launched; the
  // execute cycle itself is excluded so a stale pulse
  // cannot complete a byte the engine never saw.
  assign byte_done = pend & txrx_finished & ~txrx_execute;

  assign in_xfer = (state == PRE)  || (state == SEND) ||
                   (state == POLL) || (state == EXTRA) ||
                   (state == POST);

  // frame is shifted so its top byte is always the next
  // command byte to send.
  assign next_byte = (state == SEND) ? frame[47:40] : BYTE_FF;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      frame         <= '0;
      long_q        <= 1'b0;
      pend          <= 1'b0;
      cs            <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      txrx_execute  <= 1'b0;
      txrx_out_byte <= BYTE_FF;
      r1            <= BYTE_FF;
      resp_data     <= '0;
    end else begin
      txrx_execute <= 1'b0;
      done         <= 1'b0;

      if (in_xfer && !pend && !txrx_busy) begin
        txrx_execute  <= 1'b1;
        txrx_out_byte <= next_byte;
        pend          <= 1'b1;
      end

      if (byte_done) pend <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cmd_start) begin
            frame   <= {head, crc_byte};
            long_q  <= resp_long;
            cs      <= 1'b0;
            busy    <= 1'b1;
            timeout <= 1'b0;
            cnt     <= '0;
            state   <= PRE;
          end
        end
        PRE: begin
          if (byte_done) state <= SEND;
        end
        SEND: begin
          if (byte_done) begin
            frame <= {frame[39:0], 8'h00};
            if (cnt == SEND_LAST) begin
              cnt   <= '0;
              state <= POLL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        POLL: begin
          if (byte_done) begin
            if (!txrx_in_byte[7]) begin
              r1    <= txrx_in_byte;
              cnt   <= '0;
              state <= long_q ? EXTRA : POST;
            end else if (cnt == POLL_LAST) begin
              r1      <= BYTE_FF;
              timeout <= 1'b1;
              cnt     <= '0;
              state   <= POST;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        EXTRA: begin
          if (byte_done) begin
            resp_data <= {resp_data[23:0], txrx_in_byte};
            if (cnt == EXTRA_LAST) begin
              cnt   <= '0;
              state <= POST;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        POST: begin
          if (byte_done) begin
            cs    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed plus randomized bench for sd_cmd_sequencer with a byte
// engine / card model and a frame-level reference model.
module tb_sd_cmd_sequencer;

  localparam int POLL_MAX    = 8;
  localparam int EXTRA_BYTES = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_long;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [7:0]  r1;
  logic [31:0] resp_data;
  logic        cs;
  logic        txrx_execute;
  logic [7:0]  txrx_out_byte;
  logic [7:0]  txrx_in_byte;
  logic        txrx_finished;
  logic        txrx_busy;

  sd_cmd_sequencer #(
    .POLL_MAX    (POLL_MAX),
    .EXTRA_BYTES (EXTRA_BYTES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_start     (cmd_start),
    .cmd_index     (cmd_index),
    .cmd_arg       (cmd_arg),
    .resp_long     (resp_long),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .r1            (r1),
    .resp_data     (resp_data),
    .cs            (cs),
    .txrx_execute  (txrx_execute),
    .txrx_out_byte (txrx_out_byte),
    .txrx_in_byte  (txrx_in_byte),
    .txrx_finished (txrx_finished),
    .txrx_busy     (txrx_busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  card_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_r1;
  logic        exp_to;
  logic [31:0] exp_resp = '0;
  int          k        = 0;
  int          gap      = 0;
  int          exec_cnt = 0;
  int          done_cnt = 0;
  logic        busy_at_edge = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ans_at(input int j);
    return (j < card_q.size()) ? card_q[j] : 8'hFF;
  endfunction

  function automatic logic [7:0] crc_ref(input logic [39:0] h);
`ifdef SD_CMD_CRC7_EN
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      if (h[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
      else             c = {c[5:0], 1'b0};
    end
    return {c, 1'b1};
`else
    if (h[37:32] == 6'd0) return 8'h95;
    if (h[37:32] == 6'd8) return 8'h87;
    return 8'h01;
`endif
  endfunction

  // Card side: PRE + 6 command bytes read back 0xFF, then the
  // scripted answer stream, then idle 0xFF.
  function automatic logic [7:0] card_byte(input int n);
    return (n < 7) ? 8'hFF : ans_at(n - 7);
  endfunction

  task automatic model(input logic [5:0] idx,
                       input logic [31:0] arg,
                       input logic lng);
    logic [7:0] b;
    int p;
    bit found;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_q.push_back({2'b01, idx});
    for (int i = 3; i >= 0; i--) exp_q.push_back(arg[8*i +: 8]);
    exp_q.push_back(crc_ref({2'b01, idx, arg}));
    found = 0;
    p = 0;
    b = 8'hFF;
    while (!found && p < POLL_MAX) begin
      exp_q.push_back(8'hFF);
      b = ans_at(p);
      p++;
      if (!b[7]) found = 1;
    end
    if (found) begin
      exp_r1 = b;
      exp_to = 1'b0;
      if (lng) begin
        for (int e = 0; e < EXTRA_BYTES; e++) begin
          exp_q.push_back(8'hFF);
          exp_resp = {exp_resp[23:0], ans_at(p + e)};
        end
      end
    end else begin
      exp_r1 = 8'hFF;
      exp_to = 1'b1;
    end
    exp_q.push_back(8'hFF);
  endtask

  always @(posedge clk) busy_at_edge <= txrx_busy;

  always @(negedge clk) begin
    if (txrx_execute) exec_cnt++;
    if (done) done_cnt++;
  end

  // Byte engine: accepts execute, stays busy for 1-3 cycles,
  // pulses finished with the card byte, then an optional gap.
  initial begin
    txrx_busy     = 1'b0;
    txrx_finished = 1'b0;
    txrx_in_byte  = 8'hFF;
    forever begin
      @(posedge clk);
      #1;
      if (txrx_execute) begin
        chk("exec_while_busy", {31'd0, busy_at_edge}, 32'd0);
        tx_q.push_back(txrx_out_byte);
        txrx_busy = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        txrx_finished = 1'b1;
        txrx_in_byte  = card_byte(k);
        k++;
        @(posedge clk);
        #1;
        txrx_finished = 1'b0;
        txrx_in_byte  = 8'hFF;
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
        txrx_busy = 1'b0;
      end
    end
  end

  task automatic run_cmd(input string tag,
                         input logic [5:0] idx,
                         input logic [31:0] arg,
                         input logic lng,
                         input int g,
                         input bit hold);
    bit got;
    int d0;
    int n;
    model(idx, arg, lng);
    tx_q.delete();
    k        = 0;
    gap      = g;
    exec_cnt = 0;
    d0       = done_cnt;
    @(negedge clk);
    cmd_index = idx;
    cmd_arg   = arg;
    resp_long = lng;
    cmd_start = 1'b1;
    if (g > 0) txrx_busy = 1'b1;
    @(negedge clk);
    if (hold) begin
      cmd_index = 6'($urandom);
      cmd_arg   = $urandom;
      resp_long = ~lng;
    end else begin
      cmd_start = 1'b0;
    end
    chk({tag, "_busy_set"}, {31'd0, busy}, 32'd1);
    chk({tag, "_cs_low"}, {31'd0, cs}, 32'd0);
    if (g > 0) begin
      repeat (g - 1) @(negedge clk);
      txrx_busy = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    if (!got) begin
      $fatal(1, "FAIL %s: no done pulse within budget", tag);
    end
    chk({tag, "_r1"}, {24'd0, r1}, {24'd0, exp_r1});
    chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, exp_to});
    chk({tag, "_resp"}, resp_data, exp_resp);
    chk({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cs_high"}, {31'd0, cs}, 32'd1);
    chk({tag, "_nbytes"}, tx_q.size(), exp_q.size());
    n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, tx_q[i]},
          {24'd0, exp_q[i]});
    end
    chk({tag, "_exec_pulses"}, exec_cnt, tx_q.size());
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    if (hold) begin
      chk({tag, "_fin_ignored"}, {31'd0, busy}, 32'd0);
    end
    cmd_start = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_r1_stable"}, {24'd0, r1}, {24'd0, exp_r1});
    chk({tag, "_resp_stable"}, resp_data, exp_resp);
  endtask

  initial begin
    int d0;
    bit hit;
    reset     = 1'b1;
    cmd_start = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    resp_long = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", {31'd0, cs}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_exec", {31'd0, txrx_execute}, 32'd0);
    chk("rst_out", {24'd0, txrx_out_byte}, 32'hFF);
    chk("rst_r1", {24'd0, r1}, 32'hFF);
    chk("rst_resp", resp_data, 32'd0);
    reset = 1'b0;

    // Stray finish while idle must not disturb anything.
    @(negedge clk);
    txrx_finished = 1'b1;
    txrx_in_byte  = 8'h00;
    @(negedge clk);
    txrx_finished = 1'b0;
    txrx_in_byte  = 8'hFF;
    repeat (2) @(negedge clk);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_r1", {24'd0, r1}, 32'hFF);

    card_q = '{8'hFF, 8'h01};
    run_cmd("cmd0", 6'd0, 32'h0, 1'b0, 0, 0);

    card_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    run_cmd("cmd8", 6'd8, 32'h000001AA, 1'b1, 0, 0);

    card_q.delete();
    run_cmd("cmd17_to", 6'd17, 32'h00000010, 1'b0, 0, 0);

    card_q = '{8'hFF, 8'hFF, 8'h00};
    run_cmd("hold", 6'd55, 32'h0, 1'b0, 0, 1);

    card_q = '{8'h05, 8'h12, 8'h34, 8'h56, 8'h78};
    run_cmd("gap5", 6'd41, 32'h40000000, 1'b1, 5, 0);

    // Abort during the third command byte.
    card_q = '{8'h01};
    tx_q.delete();
    k        = 0;
    gap      = 0;
    exec_cnt = 0;
    d0       = done_cnt;
    @(negedge clk);
    cmd_index = 6'd0;
    cmd_arg   = 32'h0;
    resp_long = 1'b0;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      if (tx_q.size() >= 4) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_mid_reach", {31'd0, hit}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_cs", {31'd0, cs}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    exp_resp = '0;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_exec", {31'd0, txrx_execute}, 32'd0);
    chk("rst_mid_resp", resp_data, 32'd0);
    card_q = '{8'h01};
    run_cmd("post_rst", 6'd0, 32'h0, 1'b0, 0, 0);

    for (int t = 0; t < 8; t++) begin
      int nff;
      card_q.delete();
      nff = $urandom_range(0, 9);
      for (int i = 0; i < nff; i++) card_q.push_back(8'hFF);
      card_q.push_back(8'($urandom) & 8'h7F);
      for (int i = 0; i < 4; i++) card_q.push_back(8'($urandom));
      run_cmd($sformatf("rnd%0d", t), 6'($urandom_range(0, 63)),
              $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
